updown_counter: RTL and testbench
=================================

// Module: updown_counter
// PURPOSE
//   Free-running WIDTH-bit binary counter with run-time direction select.
//   mode=0 counts up; mode=1 counts down; the count wraps modulo 2**WIDTH in both directions.
//   Leaf block that drives a cycle/position count to surrounding control logic.
//   Built for formal property checking: all state is in one register bank, with no hidden state.
// PARAMETERS
//   WIDTH   10   counter width in bits (legal range 2..32)
// PORTS
//   clk     in   1      single clock; all state updates on rising edge
//   rst     in   1      synchronous, active-high reset
//   mode    in   1      direction: 0 = up (+1), 1 = down (-1)
//   count   out  WIDTH  current counter value, driven directly from cnt register
//   tc      out  1      terminal-count flag (present only with UPDOWN_COUNTER_TC_EN)
// BEHAVIOUR
//   - State: cnt[WIDTH-1:0]. Power-up value is undefined; no initial value is relied upon.
//   - Reset: if rst=1 at a rising clk edge, cnt <= 0 and count=0 from the next cycle on.
//     Reset overrides mode. Reset asserted mid-count clears on the first edge it is seen at.
//   - Count: if rst=0 at a rising edge:
//       mode=0 -> cnt <= cnt + 1 (mod 2**WIDTH)
//       mode=1 -> cnt <= cnt - 1 (mod 2**WIDTH)
//   - Latency: count reflects the update one cycle after the sampling edge. No enable; the counter moves every cycle.
//   - Wrap-around, up:   {WIDTH{1'b1}} -> 0.
//   - Wrap-around, down: 0 -> {WIDTH{1'b1}}. Neither wrap produces a stall or a saturation.
//   - Direction change: mode is sampled each edge; a reversal takes effect on that edge.
//     Example: 5 up, then mode=1 -> 6, then 5.
//   - Arithmetic: WIDTH-bit unsigned; the carry/borrow out is discarded.
//   - Outputs: count has no combinational path from inputs (registered only).
//   - Only rst is checked after an unknown power-up state.
//     After one reset edge, count follows the rules above deterministically.
// CONFIGURATION
//   UPDOWN_COUNTER_TC_EN defined:
//     - Adds output tc, registered. tc=1 in the cycle where count is at its terminal value for the current mode:
//       all-ones when mode=0, zero when mode=1. tc marks the value just before a wrap.
//     - tc is computed combinationally from cnt and mode and is registered together with cnt,
//       so tc and count are aligned to the same cycle.
//     - tc resets to 0 together with cnt.
//   UPDOWN_COUNTER_TC_EN undefined:
//     - No tc port or tc logic. Counting behaviour is identical.
// TESTING
//   1. Reset from arbitrary state: preload cnt=10'b1111001111, rst=1 for 1 edge
//      -> count=0; then rst=0, mode=0 -> count=1 next cycle.
//   2. Up count: after reset, mode=0 for 10 edges -> count=10. Free-run 1024 edges -> count returns to the same value.
//   3. Up wrap: count=1023, mode=0, one edge -> count=0 (tc=1 while count=1023 if TC_EN).
//   4. Down wrap: after reset, mode=1, one edge -> count=1023; next edge -> 1022 (tc=1 while count=0 if TC_EN).
//   5. Direction flip: count=5, mode=0 then mode=1 on consecutive edges -> 6, 5.
//   6. Reset priority: rst=1 with mode=1 while count=300 -> count=0 next cycle (not 299); holds 0 while rst=1.

Source files
------------

// File: rtl/updown_counter.sv
// updown_counter: free-running WIDTH-bit up/down counter.
//   mode = 0 counts up, mode = 1 counts down. Both directions wrap modulo 2**WIDTH.
//   rst is synchronous and active-high, and it overrides mode.
//   count is driven straight from the register, so there is no combinational path from the inputs.
// Optional feature: define UPDOWN_COUNTER_TC_EN to add a registered terminal-count flag tc.
//   tc is high in the same cycle in which count holds the value just before a wrap for the
//   direction in use: all-ones when counting up, zero when counting down.
//   tc is built from the next count and the mode sampled at that edge, and it is loaded
//   together with cnt, so tc and count always line up.
module updown_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    output logic [WIDTH-1:0] count
`ifdef UPDOWN_COUNTER_TC_EN
    ,
    output logic             tc
`endif
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_next;

    // Next count value. The carry or borrow out of the top bit is dropped, which gives the wrap.
    always_comb begin
        w_cnt_next = r_cnt + ONE;
        if (mode) begin
            w_cnt_next = r_cnt - ONE;
        end
    end

    // Counter register. Reset takes priority over counting in either direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign count = r_cnt;

`ifdef UPDOWN_COUNTER_TC_EN
    logic             r_tc;
    logic [WIDTH-1:0] w_term;
    logic             w_tc_next;

    // Terminal value for the current direction, compared against the value being loaded.
    always_comb begin
        w_term = '1;
        if (mode) begin
            w_term = '0;
        end
        w_tc_next = (w_cnt_next == w_term);
    end

    // The tc register is loaded alongside cnt and clears with it on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tc <= 1'b0;
        end else begin
            r_tc <= w_tc_next;
        end
    end

    assign tc = r_tc;
`endif

endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: scoreboard bench for updown_counter (WIDTH = 10).
// Each step drives rst and mode, pushes the value the bench model expects, waits one edge,
// then pops that expectation and compares it with the DUT output.
module tb_updown_counter;

    localparam int W = 10;
    localparam logic [W-1:0] ALL1 = '1;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         tc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         mode;
    logic [W-1:0] count;
`ifdef UPDOWN_COUNTER_TC_EN
    logic         tc;
`endif

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] m_cnt;
    exp_t         sb_q[$];

    updown_counter #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .count(count)
`ifdef UPDOWN_COUNTER_TC_EN
        ,
        .tc   (tc)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, push the model's expectation, then compare after the edge.
    task automatic step(input logic r, input logic m, input string tag);
        exp_t e;
        logic [W-1:0] nxt;
        rst  = r;
        mode = m;
        if (r) nxt = '0;
        else if (m) nxt = m_cnt - 10'd1;
        else nxt = m_cnt + 10'd1;
        e.cnt = nxt;
        e.tc  = !r && (nxt == (m ? '0 : ALL1));
        m_cnt = nxt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(tag, {22'd0, count}, {22'd0, e.cnt});
`ifdef UPDOWN_COUNTER_TC_EN
            check({tag, "_tc"}, {31'd0, tc}, {31'd0, e.tc});
`endif
        end
    endtask

    task automatic run(input int n, input logic r, input logic m, input string tag);
        for (int i = 0; i < n; i++) step(r, m, tag);
    endtask

    initial begin
        rst  = 1'b1;
        mode = 1'b0;
        #1;

        // 1. Reset from an arbitrary value (975 = 10'b1111001111, reached by counting down).
        step(1'b1, 1'b0, "init_rst");
        check("init_rst_zero", {22'd0, count}, 32'd0);
        run(49, 1'b0, 1'b1, "down_to_975");
        check("at_975", {22'd0, count}, 32'd975);
        step(1'b1, 1'b0, "rst_from_975");
        check("rst_from_975_zero", {22'd0, count}, 32'd0);
        step(1'b0, 1'b0, "first_up");
        check("first_up_one", {22'd0, count}, 32'd1);

        // 2. Ten up counts, then a full period returns to the same value.
        step(1'b1, 1'b0, "rst2");
        run(10, 1'b0, 1'b0, "up10");
        check("up10_val", {22'd0, count}, 32'd10);
        run(1024, 1'b0, 1'b0, "freerun");
        check("freerun_val", {22'd0, count}, 32'd10);

        // 3. Wrap while counting up.
        run(1013, 1'b0, 1'b0, "up_to_max");
        check("at_max", {22'd0, count}, 32'd1023);
`ifdef UPDOWN_COUNTER_TC_EN
        check("tc_at_max", {31'd0, tc}, 32'd1);
`endif
        step(1'b0, 1'b0, "up_wrap");
        check("up_wrap_zero", {22'd0, count}, 32'd0);

        // 4. Wrap while counting down.
        step(1'b1, 1'b1, "rst4");
        step(1'b0, 1'b1, "down_wrap");
        check("down_wrap_max", {22'd0, count}, 32'd1023);
        step(1'b0, 1'b1, "down_next");
        check("down_1022", {22'd0, count}, 32'd1022);
        run(1022, 1'b0, 1'b1, "down_to_zero");
`ifdef UPDOWN_COUNTER_TC_EN
        check("tc_at_zero_down", {31'd0, tc}, 32'd1);
`endif

        // 5. Change of direction.
        step(1'b1, 1'b0, "rst5");
        run(5, 1'b0, 1'b0, "up5");
        step(1'b0, 1'b0, "flip_up");
        check("flip_6", {22'd0, count}, 32'd6);
        step(1'b0, 1'b1, "flip_down");
        check("flip_5", {22'd0, count}, 32'd5);

        // 6. Reset wins over counting down.
        step(1'b1, 1'b0, "rst6");
        run(300, 1'b0, 1'b0, "up300");
        check("at_300", {22'd0, count}, 32'd300);
        step(1'b1, 1'b1, "rst_prio");
        check("rst_prio_zero", {22'd0, count}, 32'd0);
        step(1'b1, 1'b1, "rst_hold");
        check("rst_hold_zero", {22'd0, count}, 32'd0);
        step(1'b0, 1'b1, "after_rst_down");
        check("after_rst_1023", {22'd0, count}, 32'd1023);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
